pool_downsample_engine: RTL and testbench

- Integer-factor 2D downsampling engine on INT8 NCHW tensors in SRAM0. It is the reduction counterpart of the nearest-neighbour upsampler and shares the same command/SRAM0/status interface style.
- Each output pixel is the max, or rounded average, of a non-overlapping KxK input window (kernel = stride = K, K in {1,2,4}).
- Sits in the graph engine block and is driven by the graph sequencer, which owns SRAM0 arbitration.

---
 rtl/pool_downsample_engine_if.sv | 42 ++++
 rtl/pool_downsample_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_pool_downsample_engine.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_downsample_engine_if.sv
// Command, SRAM0 and status bundle for the pooling engine.
// slave = engine side, master = sequencer/SRAM side.
interface pool_downsample_engine_if #(
  parameter int SRAM0_AW = 16
);
  logic                cmd_valid;
  logic [15:0]         cmd_src_base;
  logic [15:0]         cmd_dst_base;
  logic [15:0]         cmd_C;
  logic [15:0]         cmd_in_H;
  logic [15:0]         cmd_in_W;
  logic [1:0]          cmd_factor_log2;
  logic                cmd_mode;
  logic                sram_rd_en;
  logic [SRAM0_AW-1:0] sram_rd_addr;
  logic [7:0]          sram_rd_data;
  logic                sram_wr_en;
  logic [SRAM0_AW-1:0] sram_wr_addr;
  logic [7:0]          sram_wr_data;
  logic                busy;
  logic                done;

  modport slave (
    input  cmd_valid, cmd_src_base, cmd_dst_base,
    input  cmd_C, cmd_in_H, cmd_in_W,
    input  cmd_factor_log2, cmd_mode,
    input  sram_rd_data,
    output sram_rd_en, sram_rd_addr,
    output sram_wr_en, sram_wr_addr, sram_wr_data,
    output busy, done
  );

  modport master (
    output cmd_valid, cmd_src_base, cmd_dst_base,
    output cmd_C, cmd_in_H, cmd_in_W,
    output cmd_factor_log2, cmd_mode,
    output sram_rd_data,
    input  sram_rd_en, sram_rd_addr,
    input  sram_wr_en, sram_wr_addr, sram_wr_data,
    input  busy, done
  );
endinterface

// File: rtl/pool_downsample_engine.sv
// INT8 NCHW KxK max / rounded-average downsampler on SRAM0.
// One element per READ/WAIT/ACC triple, one WRITE per output pixel.
module pool_downsample_engine #(
  parameter int SRAM0_AW = 16
) (
  input logic clk,
  input logic rst_n,
  pool_downsample_engine_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, ACC, WRITE, DONE
  } state_t;

  state_t state_q, state_d;

  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] ch_q, ch_d;
  logic [15:0] inw_q, inw_d;
  logic [15:0] outh_q, outh_d;
  logic [15:0] outw_q, outw_d;
  logic [15:0] istr_q, istr_d;
  logic [15:0] ostr_q, ostr_d;
  logic [1:0]  l_q, l_d;
  logic        mode_q, mode_d;

  logic [15:0] c_q, c_d;
  logic [15:0] oy_q, oy_d;
  logic [15:0] ox_q, ox_d;
  logic [1:0]  ky_q, ky_d;
  logic [1:0]  kx_q, kx_d;

  logic signed [11:0] acc_q, acc_d;

  logic                rd_en_q, rd_en_d;
  logic [SRAM0_AW-1:0] rd_addr_q, rd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [SRAM0_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                busy_q, done_q;

  logic [1:0]         cl;
  logic [15:0]        c_oh, c_ow;
  logic [1:0]         kmax;
  logic [15:0]        iy, ix, raddr, waddr;
  logic signed [11:0] smp, rnd, sum_r;
  logic [2:0]         sh;
  logic [7:0]         avg8, wdat;
  logic               last_k, last_px;

  assign cl   = (bus.cmd_factor_log2 == 2'd3) ? 2'd2
              : bus.cmd_factor_log2;
  assign c_oh = bus.cmd_in_H >> cl;
  assign c_ow = bus.cmd_in_W >> cl;

  assign kmax = (l_q == 2'd2) ? 2'd3
              : (l_q == 2'd1) ? 2'd1 : 2'd0;

  assign iy    = (oy_q << l_q) + {14'd0, ky_q};
  assign ix    = (ox_q << l_q) + {14'd0, kx_q};
  assign raddr = src_q + c_q * istr_q + iy * inw_q + ix;
  assign waddr = dst_q + c_q * ostr_q + oy_q * outw_q + ox_q;

  assign smp   = {{4{bus.sram_rd_data[7]}}, bus.sram_rd_data};
  assign rnd   = (l_q == 2'd2) ? 12'sd8
               : (l_q == 2'd1) ? 12'sd2 : 12'sd0;
  assign sum_r = acc_q + rnd;
  assign sh    = {l_q, 1'b0};
  assign avg8  = 8'(sum_r >>> sh);
  assign wdat  = mode_q ? avg8 : acc_q[7:0];

  assign last_k  = (kx_q == kmax) && (ky_q == kmax);
  assign last_px = (ox_q == outw_q - 16'd1)
                && (oy_q == outh_q - 16'd1)
                && (c_q == ch_q - 16'd1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state, window walk, accumulate and strobe generation
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    ch_d      = ch_q;
    inw_d     = inw_q;
    outh_d    = outh_q;
    outw_d    = outw_q;
    istr_d    = istr_q;
    ostr_d    = ostr_q;
    l_d       = l_q;
    mode_d    = mode_q;
    c_d       = c_q;
    oy_d      = oy_q;
    ox_d      = ox_q;
    ky_d      = ky_q;
    kx_d      = kx_q;
    acc_d     = acc_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          src_d  = bus.cmd_src_base;
          dst_d  = bus.cmd_dst_base;
          ch_d   = bus.cmd_C;
          inw_d  = bus.cmd_in_W;
          outh_d = c_oh;
          outw_d = c_ow;
          istr_d = bus.cmd_in_H * bus.cmd_in_W;
          ostr_d = c_oh * c_ow;
          l_d    = cl;
          mode_d = bus.cmd_mode;
          c_d    = 16'd0;
          oy_d   = 16'd0;
          ox_d   = 16'd0;
          ky_d   = 2'd0;
          kx_d   = 2'd0;
          if (bus.cmd_C == 16'd0 || c_oh == 16'd0
              || c_ow == 16'd0)
            state_d = DONE;
          else
            state_d = READ;
        end
      end
      READ: begin
        rd_en_d   = 1'b1;
        rd_addr_d = raddr[SRAM0_AW-1:0];
        state_d   = WAIT;
      end
      WAIT: state_d = ACC;
      ACC: begin
        if (kx_q == 2'd0 && ky_q == 2'd0)
          acc_d = smp;
        else if (mode_q)
          acc_d = acc_q + smp;
        else if (smp > acc_q)
          acc_d = smp;
        if (kx_q == kmax) begin
          kx_d = 2'd0;
          ky_d = (ky_q == kmax) ? 2'd0 : ky_q + 2'd1;
        end else begin
          kx_d = kx_q + 2'd1;
        end
        state_d = last_k ? WRITE : READ;
      end
      WRITE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = waddr[SRAM0_AW-1:0];
        wr_data_d = wdat;
        ky_d      = 2'd0;
        kx_d      = 2'd0;
        if (ox_q == outw_q - 16'd1) begin
          ox_d = 16'd0;
          if (oy_q == outh_q - 16'd1) begin
            oy_d = 16'd0;
            c_d  = c_q + 16'd1;
          end else begin
            oy_d = oy_q + 16'd1;
          end
        end else begin
          ox_d = ox_q + 16'd1;
        end
        state_d = last_px ? DONE : READ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // command fields, counters, accumulator and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      dst_q     <= '0;
      ch_q      <= '0;
      inw_q     <= '0;
      outh_q    <= '0;
      outw_q    <= '0;
      istr_q    <= '0;
      ostr_q    <= '0;
      l_q       <= '0;
      mode_q    <= 1'b0;
      c_q       <= '0;
      oy_q      <= '0;
      ox_q      <= '0;
      ky_q      <= '0;
      kx_q      <= '0;
      acc_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      src_q     <= src_d;
      dst_q     <= dst_d;
      ch_q      <= ch_d;
      inw_q     <= inw_d;
      outh_q    <= outh_d;
      outw_q    <= outw_d;
      istr_q    <= istr_d;
      ostr_q    <= ostr_d;
      l_q       <= l_d;
      mode_q    <= mode_d;
      c_q       <= c_d;
      oy_q      <= oy_d;
      ox_q      <= ox_d;
      ky_q      <= ky_d;
      kx_q      <= kx_d;
      acc_q     <= acc_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= (state_q != IDLE);
      done_q    <= (state_q == DONE);
    end
  end

  assign bus.sram_rd_en   = rd_en_q;
  assign bus.sram_rd_addr = rd_addr_q;
  assign bus.sram_wr_en   = wr_en_q;
  assign bus.sram_wr_addr = wr_addr_q;
  assign bus.sram_wr_data = wr_data_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_pool_downsample_engine.sv
// Directed bench for pool_downsample_engine.
// SRAM model plus write scoreboard.
module tb_pool_downsample_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pool_downsample_engine_if #(.SRAM0_AW(16)) bus ();

  pool_downsample_engine #(.SRAM0_AW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0] mem [0:65535];
  wr_t obs_q[$];
  wr_t exp_q[$];
  int  rp = 0;
  int  rd_cnt = 0;
  int  both_cnt = 0;
  int  done_cnt = 0;
  int  total = 0;
  int  bad = 0;

  // SRAM0 read port: data one cycle after the strobe is seen
  always @(posedge clk)
    if (bus.sram_rd_en)
      bus.sram_rd_data <= mem[bus.sram_rd_addr];

  // write capture and strobe statistics
  always @(negedge clk) begin
    if (bus.sram_wr_en)
      obs_q.push_back({bus.sram_wr_addr, bus.sram_wr_data});
    if (bus.sram_rd_en) rd_cnt++;
    if (bus.sram_rd_en && bus.sram_wr_en) both_cnt++;
    if (bus.done) done_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] o,
                       input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic put(input int a, input int v);
    mem[a[15:0]] = v[7:0];
  endtask

  task automatic exp_wr(input int a, input int v);
    exp_q.push_back({a[15:0], v[7:0]});
  endtask

  task automatic check_zero(input string tag);
    check({tag, " rd_en"}, bus.sram_rd_en, 0);
    check({tag, " wr_en"}, bus.sram_wr_en, 0);
    check({tag, " rd_addr"}, bus.sram_rd_addr, 0);
    check({tag, " wr_addr"}, bus.sram_wr_addr, 0);
    check({tag, " wr_data"}, bus.sram_wr_data, 0);
    check({tag, " busy"}, bus.busy, 0);
    check({tag, " done"}, bus.done, 0);
  endtask

  task automatic start(input logic [15:0] s, input logic [15:0] d,
                       input logic [15:0] c, input logic [15:0] h,
                       input logic [15:0] w, input logic [1:0] f,
                       input logic m);
    @(negedge clk);
    bus.cmd_src_base    = s;
    bus.cmd_dst_base    = d;
    bus.cmd_C           = c;
    bus.cmd_in_H        = h;
    bus.cmd_in_W        = w;
    bus.cmd_factor_log2 = f;
    bus.cmd_mode        = m;
    bus.cmd_valid       = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int n, input int lim, input bit poke);
    n = 0;
    while (n < lim) begin
      @(posedge clk);
      #1;
      n++;
      if (poke && n == 3) begin
        bus.cmd_dst_base = 16'h0E00;
        bus.cmd_mode     = ~bus.cmd_mode;
        bus.cmd_valid    = 1'b1;
      end
      if (poke && n == 4) bus.cmd_valid = 1'b0;
      if (bus.done) break;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    wr_t e;
    wr_t o;
    check({tag, " nwr"}, obs_q.size() - rp, exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rp < obs_q.size()) begin
        o = obs_q[rp];
        rp++;
        check({tag, " addr"}, o.a, e.a);
        check({tag, " data"}, o.d, e.d);
      end
    end
    rp = obs_q.size();
  endtask

  task automatic run(input string tag,
                     input logic [15:0] s, input logic [15:0] d,
                     input logic [15:0] c, input logic [15:0] h,
                     input logic [15:0] w, input logic [1:0] f,
                     input logic m, input int lat, input int nrd,
                     input bit poke);
    int n;
    int r0;
    int b0;
    r0 = rd_cnt;
    b0 = both_cnt;
    start(s, d, c, h, w, f, m);
    wait_done(n, lat + 30, poke);
    check({tag, " latency"}, n, lat);
    check({tag, " busy@done"}, bus.busy, 1);
    @(posedge clk);
    #1;
    check({tag, " done_1cyc"}, bus.done, 0);
    check({tag, " busy_off"}, bus.busy, 0);
    check({tag, " reads"}, rd_cnt - r0, nrd);
    check({tag, " rd_and_wr"}, both_cnt - b0, 0);
    drain(tag);
  endtask

  initial begin
    int d0;
    rst_n               = 1'b0;
    bus.cmd_valid       = 1'b0;
    bus.cmd_src_base    = '0;
    bus.cmd_dst_base    = '0;
    bus.cmd_C           = '0;
    bus.cmd_in_H        = '0;
    bus.cmd_in_W        = '0;
    bus.cmd_factor_log2 = '0;
    bus.cmd_mode        = 1'b0;

    for (int i = 0; i < 16; i++) put(i, i);
    put(16'h0200, -5);
    put(16'h0201, 7);
    put(16'h0202, -128);
    put(16'h0203, 3);
    put(16'h0204, -1);
    put(16'h0205, -2);
    put(16'h0206, -3);
    put(16'h0207, -4);
    put(16'h0400, -1);
    put(16'h0401, -1);
    put(16'h0402, -1);
    put(16'h0403, -2);
    for (int i = 4; i < 8; i++) put(16'h0400 + i, 127);
    for (int ch = 0; ch < 2; ch++)
      for (int r = 0; r < 5; r++)
        for (int x = 0; x < 3; x++)
          put(16'h0600 + ch * 15 + r * 3 + x,
              (x == 2 || r == 4) ? 127
              : -(10 * ch + 2 * r + x + 1));
    put(16'h0800, 10);
    put(16'h0801, -20);
    put(16'h0802, 30);
    put(16'h0803, -40);
    put(16'h0804, 50);
    put(16'h0805, 127);

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    exp_wr(16'h0100, 3);
    exp_wr(16'h0101, 5);
    exp_wr(16'h0102, 11);
    exp_wr(16'h0103, 13);
    run("avg_k2", 16'h0000, 16'h0100, 1, 4, 4, 2'd1, 1'b1,
        53, 16, 1'b1);

    exp_wr(16'h0300, 7);
    exp_wr(16'h0301, 8'hFF);
    run("max_k2_c2", 16'h0200, 16'h0300, 2, 2, 2, 2'd1, 1'b0,
        27, 8, 1'b0);

    exp_wr(16'h0500, 8'hFF);
    exp_wr(16'h0501, 127);
    run("avg_round", 16'h0400, 16'h0500, 2, 2, 2, 2'd1, 1'b1,
        27, 8, 1'b0);

    exp_wr(16'h0700, 8'hFF);
    exp_wr(16'h0701, 8'hFB);
    exp_wr(16'h0702, 8'hF5);
    exp_wr(16'h0703, 8'hF1);
    run("odd_5x3", 16'h0600, 16'h0700, 2, 5, 3, 2'd1, 1'b0,
        53, 16, 1'b0);

    run("degen_h1", 16'h0000, 16'h0F00, 1, 1, 4, 2'd1, 1'b1,
        1, 0, 1'b0);
    run("degen_c0", 16'h0000, 16'h0F00, 0, 4, 4, 2'd1, 1'b0,
        1, 0, 1'b0);

    exp_wr(16'h0900, 10);
    exp_wr(16'h0901, -20);
    exp_wr(16'h0902, 30);
    exp_wr(16'h0903, -40);
    exp_wr(16'h0904, 50);
    exp_wr(16'h0905, 127);
    run("copy_k1", 16'h0800, 16'h0900, 1, 2, 3, 2'd0, 1'b1,
        25, 6, 1'b0);

    exp_wr(16'h0A00, 8);
    run("avg_f3", 16'h0000, 16'h0A00, 1, 4, 4, 2'd3, 1'b1,
        50, 16, 1'b0);
    exp_wr(16'h0A10, 15);
    run("max_k4", 16'h0000, 16'h0A10, 1, 4, 4, 2'd2, 1'b0,
        50, 16, 1'b0);

    d0 = done_cnt;
    exp_wr(16'h0B00, 3);
    start(16'h0000, 16'h0B00, 1, 4, 4, 2'd1, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) begin
        bus.cmd_dst_base = 16'h0C00;
        bus.cmd_valid    = 1'b1;
      end
      if (k == 6) bus.cmd_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst no_done", done_cnt - d0, 0);
    check("midrst idle", bus.busy, 0);
    drain("midrst");

    exp_wr(16'h0D00, 3);
    exp_wr(16'h0D01, 5);
    exp_wr(16'h0D02, 11);
    exp_wr(16'h0D03, 13);
    run("restart", 16'h0000, 16'h0D00, 1, 4, 4, 2'd1, 1'b1,
        53, 16, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
